aircon_zone_ctrl: RTL

Multi-zone thermostat controller, the parametrised successor to the single-zone aircon controller. It runs one independent hysteresis state machine (IDLE/HEAT/COOL) per zone, and each machine enforces a minimum dwell time before it may change state. Each zone drives heating and cooling enables, a 24-bit RGB status light and a state-change pulse. It sits between the temperature sensor interface and the HVAC actuator and LED drivers.

---
 rtl/aircon_zone_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/aircon_zone_ctrl.sv
// Multi-zone thermostat: one independent IDLE/HEAT/COOL hysteresis machine per zone,
// each with a minimum dwell time, driving heater/cooler enables, an RGB light and a change pulse.
module aircon_zone_ctrl #(
    parameter int N_ZONES   = 2,
    parameter int TEMP_W    = 6,
    parameter int HEAT_ON   = 18,
    parameter int HEAT_OFF  = 20,
    parameter int COOL_OFF  = 20,
    parameter int COOL_ON   = 22,
    parameter int MIN_DWELL = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_ZONES-1:0]        zone_en,
    input  logic [N_ZONES*TEMP_W-1:0] temperature,
    output logic [N_ZONES-1:0]        heating,
    output logic [N_ZONES-1:0]        cooling,
    output logic [N_ZONES-1:0]        state_chg,
    output logic [N_ZONES*24-1:0]     aircon_light
);

    // A zero dwell still needs a one-bit counter; it simply stays at zero.
    localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

    localparam logic [DW-1:0]     DWELL_MAX  = DW'(MIN_DWELL);
    localparam logic [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);
    localparam logic [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_HEAT    = 2'b01;
    localparam logic [1:0] ST_COOL    = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [23:0] LIGHT_IDLE = 24'h00FF00;
    localparam logic [23:0] LIGHT_HEAT = 24'hFF0000;
    localparam logic [23:0] LIGHT_COOL = 24'h0000FF;
    localparam logic [23:0] LIGHT_OFF  = 24'h000000;

    // The ordering guarantees the two IDLE exits are mutually exclusive.
    if (!(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF && COOL_OFF < COOL_ON)) begin : g_bad_thresholds
        $error("aircon_zone_ctrl: thresholds must satisfy HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON");
    end

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        logic [TEMP_W-1:0] temp_in;
        logic [TEMP_W-1:0] temp_d, temp_q;
        logic [1:0]        state_d, state_q;
        logic [DW-1:0]     dwell_d, dwell_q;
        logic              chg_d, chg_q;
        logic [1:0]        want_state;

        assign temp_in = temperature[i*TEMP_W +: TEMP_W];

        // Hysteresis decision on the registered temperature, ignoring dwell.
        always_comb begin
            want_state = state_q;
            case (state_q)
                ST_IDLE: begin
                    if (temp_q <= T_HEAT_ON) begin
                        want_state = ST_HEAT;
                    end else if (temp_q >= T_COOL_ON) begin
                        want_state = ST_COOL;
                    end
                end
                ST_HEAT: if (temp_q >= T_HEAT_OFF) want_state = ST_IDLE;
                ST_COOL: if (temp_q <= T_COOL_OFF) want_state = ST_IDLE;
                default: want_state = ST_IDLE;
            endcase
        end

        always_comb begin
            temp_d  = temp_in;
            state_d = state_q;
            dwell_d = dwell_q;
            chg_d   = 1'b0;
            if (!zone_en[i]) begin
                // Disable bypasses dwell and leaves the counter saturated for an immediate reaction on re-enable.
                state_d = ST_IDLE;
                dwell_d = DWELL_MAX;
                chg_d   = (state_q != ST_IDLE);
            end else if (want_state != state_q &&
                         (dwell_q == DWELL_MAX || state_q == ST_ILLEGAL)) begin
                state_d = want_state;
                dwell_d = '0;
                chg_d   = 1'b1;
            end else if (dwell_q != DWELL_MAX) begin
                dwell_d = dwell_q + 1'b1;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                temp_q  <= T_HEAT_OFF;
                state_q <= ST_IDLE;
                dwell_q <= DWELL_MAX;
                chg_q   <= 1'b0;
            end else begin
                temp_q  <= temp_d;
                state_q <= state_d;
                dwell_q <= dwell_d;
                chg_q   <= chg_d;
            end
        end

        assign heating[i]   = (state_q == ST_HEAT) & zone_en[i];
        assign cooling[i]   = (state_q == ST_COOL) & zone_en[i];
        assign state_chg[i] = chg_q;

        always_comb begin
            aircon_light[i*24 +: 24] = LIGHT_OFF;
            if (zone_en[i]) begin
                case (state_q)
                    ST_IDLE: aircon_light[i*24 +: 24] = LIGHT_IDLE;
                    ST_HEAT: aircon_light[i*24 +: 24] = LIGHT_HEAT;
                    ST_COOL: aircon_light[i*24 +: 24] = LIGHT_COOL;
                    default: aircon_light[i*24 +: 24] = LIGHT_OFF;
                endcase
            end
        end
    end

endmodule
